readptr_status: RTL and testbench

Parametrised next-generation read-side pointer and status block for the async FIFO, running entirely in the read clock domain.
- Maintains binary and Gray read pointers and computes registered empty, fill level and programmable almost-empty flags from the synchronised Gray write pointer.
- Flags underflow attempts with a sticky bit.
- Optionally adds a first-word-fall-through (FWFT) output register with a valid/ready handshake in front of the async-read FIFO memory.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/rd_fwft_stage.sv | 57 +++++
 rtl/readptr_status.sv | 115 +++++++++++
 tb/tb_readptr_status.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the FIFO read side.
// Pointer helpers work on a wide container type; callers zero-extend their
// (A_SIZE+1)-bit pointer into it and slice the result back out. Zero upper
// bits are transparent to both Gray conversions.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_VALID = 1'b1
   } rd_state_e;

   function automatic ptr_t bin2gray(input ptr_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_fwft_stage.sv
// First-word-fall-through output register: holds one word presented to the
// consumer with a valid/ready handshake, refilled from the async-read memory.
module rd_fwft_stage
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              pop,
   input  logic              r_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              r_valid,
   output logic [DATA_W-1:0] r_data
);

   rd_state_e         state_reg;
   logic              r_valid_reg;
   logic [DATA_W-1:0] r_data_reg;

   // Output register state machine; a pop always loads the word at the current read address.
   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state_reg   <= RD_IDLE;
         r_valid_reg <= 1'b0;
         r_data_reg  <= '0;
      end else begin
         case (state_reg)
            RD_IDLE: begin
               if (pop) begin
                  r_data_reg  <= mem_rdata;
                  r_valid_reg <= 1'b1;
                  state_reg   <= RD_VALID;
               end
            end
            RD_VALID: begin
               if (r_ready) begin
                  if (pop) begin
                     r_data_reg <= mem_rdata;
                  end else begin
                     r_valid_reg <= 1'b0;
                     state_reg   <= RD_IDLE;
                  end
               end
            end
            default: begin
               r_valid_reg <= 1'b0;
               state_reg   <= RD_IDLE;
            end
         endcase
      end
   end

   assign r_valid = r_valid_reg;
   assign r_data  = r_data_reg;

endmodule

// File: rtl/readptr_status.sv
// Read-side pointer and status block of the async FIFO (read clock domain).
// Keeps binary/Gray read pointers, registered empty/level/almost-empty
// derived from the synchronised write pointer, a sticky underflow flag and
// an optional FWFT output stage.
module readptr_status
   import fifo_pkg::*;
#(
   parameter int A_SIZE = 9,
   parameter int DATA_W = 8,
   parameter int FWFT   = 0,
   parameter int AE_RST = 2
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              r_inc,
   input  logic [A_SIZE:0]   wptr_sync,
   input  logic [A_SIZE:0]   ae_thresh,
   input  logic              r_uf_clr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              r_ready,
   output logic [A_SIZE-1:0] rmem_addr,
   output logic [A_SIZE:0]   raddr,
   output logic [A_SIZE:0]   rptr,
   output logic              rempty,
   output logic              ralmost_empty,
   output logic [A_SIZE:0]   rlevel,
   output logic              runderflow,
   output logic              r_valid,
   output logic [DATA_W-1:0] r_data
);

   localparam int PW = A_SIZE + 1;

   logic [A_SIZE:0] raddr_reg, raddr_next;
   logic [A_SIZE:0] rptr_reg, rptr_next;
   logic [A_SIZE:0] rlevel_reg, level_next;
   logic [A_SIZE:0] wbin;
   logic            rempty_reg, rae_reg, ruf_reg, ruf_next;
   logic            pop, uf_set, r_valid_int;
   ptr_t            raddr_ext, wptr_ext, rgray_ext, wbin_ext;
   logic            unused_bits;

   // Pop qualification and underflow detection depend on the read mode.
   generate
      if (FWFT != 0) begin : g_fwft
         rd_fwft_stage #(
            .DATA_W (DATA_W)
         ) u_fwft (
            .r_clk     (r_clk),
            .r_rst     (r_rst),
            .pop       (pop),
            .r_ready   (r_ready),
            .mem_rdata (mem_rdata),
            .r_valid   (r_valid_int),
            .r_data    (r_data)
         );
         assign pop    = !rempty_reg && (!r_valid_int || r_ready);
         assign uf_set = 1'b0;
      end else begin : g_std
         assign r_valid_int = 1'b0;
         assign r_data      = '0;
         assign pop         = r_inc && !rempty_reg;
         assign uf_set      = r_inc && rempty_reg;
      end
   endgenerate

   // Next pointer values and the status they imply against the stale write pointer.
   always_comb begin
      raddr_next           = raddr_reg + {{A_SIZE{1'b0}}, pop};
      raddr_ext            = '0;
      raddr_ext[A_SIZE:0]  = raddr_next;
      rgray_ext            = bin2gray(raddr_ext);
      rptr_next            = rgray_ext[A_SIZE:0];
      wptr_ext             = '0;
      wptr_ext[A_SIZE:0]   = wptr_sync;
      wbin_ext             = gray2bin(wptr_ext);
      wbin                 = wbin_ext[A_SIZE:0];
      level_next           = wbin - raddr_next;
      // Setting the flag takes priority over a simultaneous clear.
      ruf_next             = uf_set ? 1'b1 : (r_uf_clr ? 1'b0 : ruf_reg);
   end

   // Register pointers and status; everything is one cycle behind the pop.
   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         raddr_reg  <= '0;
         rptr_reg   <= '0;
         rempty_reg <= 1'b1;
         rlevel_reg <= '0;
         rae_reg    <= 1'b1;
         ruf_reg    <= 1'b0;
      end else begin
         raddr_reg  <= raddr_next;
         rptr_reg   <= rptr_next;
         rempty_reg <= (rptr_next == wptr_sync);
         rlevel_reg <= level_next;
         rae_reg    <= (level_next <= ae_thresh);
         ruf_reg    <= ruf_next;
      end
   end

   assign rmem_addr     = raddr_reg[A_SIZE-1:0];
   assign raddr         = raddr_reg;
   assign rptr          = rptr_reg;
   assign rempty        = rempty_reg;
   assign rlevel        = rlevel_reg;
   assign ralmost_empty = rae_reg;
   assign runderflow    = ruf_reg;
   assign r_valid       = r_valid_int;

   // Upper container bits and mode-specific inputs are intentionally dropped.
   assign unused_bits = ^{rgray_ext[PTR_MAX_W-1:PW], wbin_ext[PTR_MAX_W-1:PW],
                          mem_rdata, r_ready, r_inc};

endmodule

// File: tb/tb_readptr_status.sv
// Self-checking bench for readptr_status: a standard-read instance against a
// count-based reference model, and an FWFT instance against a word scoreboard.
module tb_readptr_status;

   localparam int AS = 4;
   localparam int DW = 8;

   logic r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   // standard-read instance
   logic          rst, inc, uf_clr, rdy_s;
   logic [AS:0]   wptr, thr;
   logic [DW-1:0] mdata_s;
   logic [AS-1:0] rmem_addr;
   logic [AS:0]   raddr, rptr, rlevel;
   logic          rempty, rae, ruf, rvalid_s;
   logic [DW-1:0] rdata_s;

   // FWFT instance
   logic          f_rst, f_inc, f_clr, f_ready;
   logic [AS:0]   f_wptr, f_thr;
   logic [DW-1:0] f_mem;
   logic [AS-1:0] f_rmem_addr;
   logic [AS:0]   f_raddr, f_rptr, f_rlevel;
   logic          f_rempty, f_rae, f_ruf, f_rvalid;
   logic [DW-1:0] f_rdata;

   logic [DW-1:0] mem [16];
   assign f_mem = mem[f_rmem_addr];

   readptr_status #(.A_SIZE(AS), .DATA_W(DW), .FWFT(0), .AE_RST(2)) dut (
      .r_clk(r_clk), .r_rst(rst), .r_inc(inc), .wptr_sync(wptr), .ae_thresh(thr),
      .r_uf_clr(uf_clr), .mem_rdata(mdata_s), .r_ready(rdy_s), .rmem_addr(rmem_addr),
      .raddr(raddr), .rptr(rptr), .rempty(rempty), .ralmost_empty(rae), .rlevel(rlevel),
      .runderflow(ruf), .r_valid(rvalid_s), .r_data(rdata_s));

   readptr_status #(.A_SIZE(AS), .DATA_W(DW), .FWFT(1), .AE_RST(2)) dut_f (
      .r_clk(r_clk), .r_rst(f_rst), .r_inc(f_inc), .wptr_sync(f_wptr), .ae_thresh(f_thr),
      .r_uf_clr(f_clr), .mem_rdata(f_mem), .r_ready(f_ready), .rmem_addr(f_rmem_addr),
      .raddr(f_raddr), .rptr(f_rptr), .rempty(f_rempty), .ralmost_empty(f_rae), .rlevel(f_rlevel),
      .runderflow(f_ruf), .r_valid(f_rvalid), .r_data(f_rdata));

   int n_run  = 0;
   int n_fail = 0;

   // reference model: read count, stored-word count and flags
   int m_raddr, m_level;
   bit m_empty, m_ae, m_uf;

   function automatic logic [AS:0] gray(input int v);
      logic [AS:0] b;
      b = v[AS:0];
      return b ^ (b >> 1);
   endfunction

   task automatic m_reset();
      m_raddr = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
   endtask

   // one clock of the spec rules: pop if data is there, level = writes - reads
   task automatic m_step(input bit i, input int w, input int t, input bit c);
      bit p;
      p = i && !m_empty;
      if (i && m_empty) m_uf = 1;
      else if (c)       m_uf = 0;
      m_raddr = (m_raddr + (p ? 1 : 0)) % 32;
      m_level = ((w - m_raddr) % 32 + 32) % 32;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= t);
   endtask

   task automatic cyc(input bit i, input int w, input int t, input bit c);
      inc = i; wptr = gray(w); thr = t[AS:0]; uf_clr = c;
      @(posedge r_clk);
      m_step(i, w, t, c);
      #1;
   endtask

   task automatic test_reset();
      rst = 0; inc = 1; uf_clr = 0; wptr = 5'h03; thr = 5'd2;
      m_reset();
      for (int k = 0; k < 2; k++) begin
         @(posedge r_clk); #1;
         n_run++;
         if ({raddr, rptr, rempty, rlevel, rae, ruf} !== {5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset%0d: got raddr=%0d rptr=%h empty=%b level=%0d ae=%b uf=%b, want 0 0 1 0 1 0",
                     k, raddr, rptr, rempty, rlevel, rae, ruf);
         end else $display("[TB] reset%0d ok", k);
      end
      rst = 1;
   endtask

   task automatic test_basic_read();
      bit ii;
      for (int k = 0; k < 5; k++) begin
         ii = (k >= 1 && k <= 3);
         cyc(ii, 3, 2, 0);
         n_run++;
         if ({raddr, rptr, rempty, rlevel, rae, ruf} !==
             {m_raddr[AS:0], gray(m_raddr), m_empty, m_level[AS:0], m_ae, m_uf}) begin
            n_fail++;
            $display("FAIL basic%0d: got raddr=%0d rptr=%h empty=%b level=%0d ae=%b uf=%b, want %0d %h %b %0d %b %b",
                     k, raddr, rptr, rempty, rlevel, rae, ruf,
                     m_raddr, gray(m_raddr), m_empty, m_level, m_ae, m_uf);
         end else $display("[TB] basic%0d raddr=%0d level=%0d", k, raddr, rlevel);
      end
      n_run++;
      if ({raddr, rptr, rempty} !== {5'd3, 5'h02, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_end: got raddr=%0d rptr=%h empty=%b, want 3 02 1", raddr, rptr, rempty);
      end
   endtask

   task automatic test_underflow();
      bit ii, cc;
      // r_inc on empty, then inc+clear together, then clear alone, then idle
      for (int k = 0; k < 4; k++) begin
         ii = (k <= 1);
         cc = (k == 1 || k == 2);
         cyc(ii, 3, 2, cc);
         n_run++;
         if ({raddr, rptr, rempty, rlevel, ruf} !==
             {m_raddr[AS:0], gray(m_raddr), m_empty, m_level[AS:0], m_uf}) begin
            n_fail++;
            $display("FAIL underflow%0d: got raddr=%0d empty=%b uf=%b, want %0d %b %b",
                     k, raddr, rempty, ruf, m_raddr, m_empty, m_uf);
         end else $display("[TB] underflow%0d uf=%b", k, ruf);
      end
   endtask

   task automatic test_wrap();
      rst = 0; m_reset(); @(posedge r_clk); #1; rst = 1;
      cyc(0, 16, 2, 0);
      for (int k = 0; k < 16; k++) cyc(1, 16, 2, 0);
      cyc(0, 0, 2, 0);
      for (int k = 0; k < 15; k++) cyc(1, 0, 2, 0);
      n_run++;
      if ({raddr, rlevel} !== {5'd31, 5'd1}) begin
         n_fail++;
         $display("FAIL wrap_pre: got raddr=%0d level=%0d, want 31 1", raddr, rlevel);
      end
      for (int k = 0; k < 2; k++) begin
         cyc(1, 1, 2, 0);
         n_run++;
         if ({raddr, rptr, rempty, rlevel, rae, ruf} !==
             {m_raddr[AS:0], gray(m_raddr), m_empty, m_level[AS:0], m_ae, m_uf}) begin
            n_fail++;
            $display("FAIL wrap%0d: got raddr=%0d rptr=%h empty=%b level=%0d, want %0d %h %b %0d",
                     k, raddr, rptr, rempty, rlevel, m_raddr, gray(m_raddr), m_empty, m_level);
         end else $display("[TB] wrap%0d raddr=%0d level=%0d", k, raddr, rlevel);
      end
      n_run++;
      if ({raddr, rempty} !== {5'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_end: got raddr=%0d empty=%b, want 1 1", raddr, rempty);
      end
   endtask

   task automatic test_full_level();
      rst = 0; m_reset(); @(posedge r_clk); #1; rst = 1;
      cyc(0, 16, 2, 0);
      n_run++;
      if ({rlevel, rempty, rae} !== {5'd16, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL full: got level=%0d empty=%b ae=%b, want 16 0 0", rlevel, rempty, rae);
      end else $display("[TB] full level=%0d", rlevel);
      cyc(0, 16, 20, 0);
      n_run++;
      if (rae !== 1'b1) begin
         n_fail++;
         $display("FAIL ae_big_thresh: got ae=%b, want 1", rae);
      end else $display("[TB] ae with thresh 20 ok");
   endtask

   task automatic test_random();
      int w, t;
      bit ii, cc;
      rst = 0; m_reset(); @(posedge r_clk); #1; rst = 1;
      w = 0;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 1) == 1 && (((w - m_raddr) % 32 + 32) % 32) < 16) w = (w + 1) % 32;
         ii = ($urandom_range(0, 3) != 0);
         cc = ($urandom_range(0, 7) == 0);
         t  = $urandom_range(0, 31);
         cyc(ii, w, t, cc);
         n_run++;
         if ({raddr, rptr, rempty, rlevel, rae, ruf} !==
             {m_raddr[AS:0], gray(m_raddr), m_empty, m_level[AS:0], m_ae, m_uf}) begin
            n_fail++;
            $display("FAIL rand%0d: got raddr=%0d rptr=%h empty=%b level=%0d ae=%b uf=%b, want %0d %h %b %0d %b %b",
                     k, raddr, rptr, rempty, rlevel, rae, ruf,
                     m_raddr, gray(m_raddr), m_empty, m_level, m_ae, m_uf);
         end else $display("[TB] rand%0d inc=%b raddr=%0d level=%0d", k, ii, raddr, rlevel);
      end
      // reset in the middle of traffic wins over r_inc
      rst = 0; inc = 1; @(posedge r_clk); #1;
      n_run++;
      if ({raddr, rempty, rlevel, rae, ruf} !== {5'd0, 1'b1, 5'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset: got raddr=%0d empty=%b level=%0d ae=%b uf=%b, want 0 1 0 1 0",
                  raddr, rempty, rlevel, rae, ruf);
      end else $display("[TB] mid reset ok");
      rst = 1; inc = 0;
   endtask

   task automatic test_fwft_directed();
      f_rst = 0; f_wptr = '0; f_ready = 0;
      repeat (2) @(posedge r_clk);
      #1;
      n_run++;
      if ({f_rvalid, f_rdata, f_rempty} !== {1'b0, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL fwft_reset: got valid=%b data=%h empty=%b, want 0 00 1", f_rvalid, f_rdata, f_rempty);
      end
      mem[0] = 8'hA5; mem[1] = 8'h3C;
      f_rst = 1; f_wptr = gray(2);
      @(posedge r_clk); #1;
      @(posedge r_clk); #1;
      n_run++;
      if ({f_rvalid, f_rdata, f_raddr} !== {1'b1, 8'hA5, 5'd1}) begin
         n_fail++;
         $display("FAIL fwft_first: got valid=%b data=%h raddr=%0d, want 1 a5 1", f_rvalid, f_rdata, f_raddr);
      end else $display("[TB] fwft first word %h", f_rdata);
      @(posedge r_clk); #1;
      n_run++;
      if ({f_rvalid, f_rdata, f_raddr} !== {1'b1, 8'hA5, 5'd1}) begin
         n_fail++;
         $display("FAIL fwft_hold: got valid=%b data=%h raddr=%0d, want 1 a5 1", f_rvalid, f_rdata, f_raddr);
      end else $display("[TB] fwft hold %h", f_rdata);
      f_ready = 1;
      @(posedge r_clk); #1;
      n_run++;
      if ({f_rvalid, f_rdata, f_raddr, f_rempty} !== {1'b1, 8'h3C, 5'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL fwft_second: got valid=%b data=%h raddr=%0d empty=%b, want 1 3c 2 1",
                  f_rvalid, f_rdata, f_raddr, f_rempty);
      end else $display("[TB] fwft second word %h", f_rdata);
      @(posedge r_clk); #1;
      n_run++;
      if ({f_rvalid, f_raddr, f_rempty, f_ruf} !== {1'b0, 5'd2, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL fwft_drain: got valid=%b raddr=%0d empty=%b uf=%b, want 0 2 1 0",
                  f_rvalid, f_raddr, f_rempty, f_ruf);
      end else $display("[TB] fwft drained");
      f_ready = 0;
   endtask

   task automatic test_fwft_random();
      logic [DW-1:0] q[$];
      logic [DW-1:0] d;
      int written, consumed;
      f_rst = 0; f_ready = 0; f_wptr = '0;
      @(posedge r_clk); #1;
      f_rst = 1;
      written = 0; consumed = 0;
      for (int k = 0; k < 400 + 100; k++) begin
         if (k >= 400 && consumed == written) break;
         f_ready = (k >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (f_rvalid && f_ready) begin
            n_run++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL fwft_extra: got word %h with nothing stored", f_rdata);
            end else begin
               d = q.pop_front();
               if (f_rdata !== d) begin
                  n_fail++;
                  $display("FAIL fwft_word%0d: got %h, want %h", consumed, f_rdata, d);
               end else $display("[TB] fwft word%0d %h", consumed, f_rdata);
            end
            consumed++;
         end
         if (k < 400 && (written - consumed) < 14 && $urandom_range(0, 1) == 1) begin
            d = 8'($urandom_range(0, 255));
            mem[written % 16] = d;
            q.push_back(d);
            written++;
            f_wptr = gray(written % 32);
         end
         @(posedge r_clk); #1;
      end
      n_run++;
      if (consumed != written || f_ruf !== 1'b0) begin
         n_fail++;
         $display("FAIL fwft_count: got consumed=%0d uf=%b, want %0d 0", consumed, f_ruf, written);
      end else $display("[TB] fwft random %0d words", consumed);
   endtask

   initial begin
      rst = 0; inc = 0; uf_clr = 0; rdy_s = 0; mdata_s = '0; wptr = '0; thr = 5'd2;
      f_rst = 0; f_inc = 0; f_clr = 0; f_ready = 0; f_wptr = '0; f_thr = 5'd2;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      #1;
      test_reset();
      test_basic_read();
      test_underflow();
      test_wrap();
      test_full_level();
      test_random();
      test_fwft_directed();
      test_fwft_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
